slot_reel_engine: RTL and testbench

Parametrised slot-machine core: N reels spun by one start button, stopped individually by per-reel buttons, with match judgement, a timed fever LED effect and an internal multiplexed display scan. It sits under the slot-machine top level, between the push-button inputs and the seven-segment pattern decoder. It runs entirely from the single system clock; display scan rate comes from an internal prescaler rather than a second clock.

---
 rtl/slot_pkg.sv | 20 ++
 rtl/slot_reel.sv | 30 +++
 rtl/slot_reel_engine.sv | 166 ++++++++++++++++
 tb/tb_slot_reel_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared types and default configuration for the slot reel engine.
package slot_pkg;

  typedef enum logic [1:0] {IDLE, SPIN, JUDGE, FEVER} state_e;

  localparam int DEF_REELS        = 3;
  localparam int DEF_SYMBOLS      = 8;
  localparam int DEF_SPIN_DIV     = 4;
  localparam int DEF_SCAN_DIV     = 16;
  localparam int DEF_FEVER_CYCLES = 64;
  localparam int DEF_LED_W        = 8;
  localparam int DEF_CREDIT_W     = 8;
  localparam int DEF_INIT_CREDIT  = 5;
  localparam int DEF_PAYOUT       = 10;

  function automatic int sym_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slot_reel.sv
// One reel: modulo symbol counter that rolls on step ticks until its stop arrives.
module slot_reel import slot_pkg::*; #(
  parameter  int SYMBOLS = DEF_SYMBOLS,
  localparam int SYM_W   = sym_w(SYMBOLS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             roll,
  input  logic             step,
  input  logic             stop,
  output logic [SYM_W-1:0] sym,
  output logic             frozen
);

  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(SYMBOLS - 1);

  // A stop in the same cycle as a step tick wins, so the reel keeps its pre-tick symbol.
  always_ff @(posedge clock) begin
    if (reset) begin
      sym    <= '0;
      frozen <= 1'b1;
    end else if (roll) begin
      frozen <= 1'b0;
    end else if (!frozen) begin
      if (stop)      frozen <= 1'b1;
      else if (step) sym    <= (sym == SYM_LAST) ? '0 : sym + 1'b1;
    end
  end

endmodule

// File: rtl/slot_reel_engine.sv
// Slot-machine core: spin/stop/judge/fever FSM, LED walk and display scan.
// Optional credit counter enabled by defining SLOT_CREDIT_EN.
module slot_reel_engine import slot_pkg::*; #(
  parameter  int REELS        = DEF_REELS,
  parameter  int SYMBOLS      = DEF_SYMBOLS,
  parameter  int SPIN_DIV     = DEF_SPIN_DIV,
  parameter  int SCAN_DIV     = DEF_SCAN_DIV,
  parameter  int FEVER_CYCLES = DEF_FEVER_CYCLES,
  parameter  int LED_W        = DEF_LED_W,
  parameter  int CREDIT_W     = DEF_CREDIT_W,
  parameter  int INIT_CREDIT  = DEF_INIT_CREDIT,
  parameter  int PAYOUT       = DEF_PAYOUT,
  localparam int SYM_W        = sym_w(SYMBOLS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [REELS-1:0]       stop,
  output logic [REELS*SYM_W-1:0] reel,
  output logic [REELS-1:0]       digit,
  output logic [SYM_W-1:0]       scan_symbol,
  output logic                   running,
  output logic                   fever,
  output logic [LED_W-1:0]       led,
  output logic [CREDIT_W-1:0]    credit
);

  localparam int SP_W  = $clog2(SPIN_DIV);
  localparam int SC_W  = $clog2(SCAN_DIV);
  localparam int FC_W  = $clog2(FEVER_CYCLES + 1);
  localparam int IDX_W = $clog2(REELS);
  localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(SPIN_DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FEVER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(REELS - 1);

  state_e                        state, state_n;
  logic                          start_q, start_edge, accept, credit_ok;
  logic [REELS-1:0]              stop_q, stop_edge, stop_gate, frozen;
  logic                          tick, load, to_fever, all_frozen, all_equal;
  logic [SP_W-1:0]               spin_pre;
  logic [SC_W-1:0]               scan_pre;
  logic [FC_W-1:0]               fev_cnt;
  logic [IDX_W-1:0]              scan_idx;
  logic [REELS-1:0][SYM_W-1:0]   sym;

  // Button history runs in every state so a button held across a state change never counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b0;
      stop_q  <= '0;
    end else begin
      start_q <= start;
      stop_q  <= stop;
    end
  end

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop & ~stop_q;
  assign accept     = start_edge & credit_ok;
  assign stop_gate  = (state == SPIN) ? stop_edge : '0;
  assign tick       = (state == SPIN) && (spin_pre == SP_LAST);
  assign all_frozen = &(frozen | stop_gate);

  always_comb begin
    all_equal = 1'b1;
    for (int i = 1; i < REELS; i++)
      if (sym[i] != sym[0]) all_equal = 1'b0;
  end

  for (genvar i = 0; i < REELS; i++) begin : g_reel
    slot_reel #(.SYMBOLS(SYMBOLS)) u_reel (
      .clock  (clock),
      .reset  (reset),
      .roll   (load),
      .step   (tick),
      .stop   (stop_gate[i]),
      .sym    (sym[i]),
      .frozen (frozen[i])
    );
  end
  assign reel = sym;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    to_fever = 1'b0;
    case (state)
      IDLE:  if (accept) begin
               state_n = SPIN;
               load    = 1'b1;
             end
      SPIN:  if (all_frozen) state_n = JUDGE;
      JUDGE: if (all_equal) begin
               state_n  = FEVER;
               to_fever = 1'b1;
             end else begin
               state_n  = IDLE;
             end
      FEVER: if (fev_cnt == FC_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The spin prescaler also paces the LED walk, so it restarts on entry to FEVER.
  always_ff @(posedge clock) begin
    if (reset) begin
      spin_pre <= '0;
      fev_cnt  <= '0;
      led      <= '0;
      running  <= 1'b0;
      fever    <= 1'b0;
    end else begin
      running <= (state_n == SPIN);
      fever   <= (state_n == FEVER);
      if (load || to_fever || spin_pre == SP_LAST) spin_pre <= '0;
      else                                         spin_pre <= spin_pre + 1'b1;
      if (to_fever)            fev_cnt <= '0;
      else if (state == FEVER) fev_cnt <= fev_cnt + 1'b1;
      if (to_fever) led <= LED_W'(1);
      else if (state == FEVER) begin
        if (fev_cnt == FC_LAST)      led <= '0;
        else if (spin_pre == SP_LAST) led <= {led[LED_W-2:0], led[LED_W-1]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scan_pre <= '0;
      scan_idx <= '0;
      digit    <= REELS'(1);
    end else if (scan_pre == SC_LAST) begin
      scan_pre <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      digit    <= {digit[REELS-2:0], digit[REELS-1]};
    end else begin
      scan_pre <= scan_pre + 1'b1;
    end
  end

  assign scan_symbol = sym[scan_idx];

`ifdef SLOT_CREDIT_EN
  logic [CREDIT_W:0] credit_sum;
  assign credit_ok  = (credit != '0);
  assign credit_sum = {1'b0, credit} + (CREDIT_W+1)'(PAYOUT);

  always_ff @(posedge clock) begin
    if (reset)         credit <= CREDIT_W'(INIT_CREDIT);
    else if (load)     credit <= credit - 1'b1;
    else if (to_fever) credit <= credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{INIT_CREDIT, PAYOUT};
  assign credit_ok  = 1'b1;
  assign credit     = '0;
`endif

endmodule

// File: tb/tb_slot_reel_engine.sv
// Bench for slot_reel_engine: directed table rounds, corner sequences and random
// stimulus, all checked every cycle against a time-based behavioural model.
module tb_slot_reel_engine;

  localparam int REELS = 3, SYMBOLS = 8, SPIN_DIV = 4, SCAN_DIV = 16;
  localparam int FEVER_CYCLES = 64, LED_W = 8, CREDIT_W = 8, INIT_CREDIT = 5, PAYOUT = 10;
  localparam int SYM_W = $clog2(SYMBOLS);
  localparam int M_IDLE = 0, M_SPIN = 1, M_JUDGE = 2, M_FEVER = 3;

  logic                   clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [REELS-1:0]       stop = '0;
  logic [REELS*SYM_W-1:0] reel;
  logic [REELS-1:0]       digit;
  logic [SYM_W-1:0]       scan_symbol;
  logic                   running, fever;
  logic [LED_W-1:0]       led;
  logic [CREDIT_W-1:0]    credit;

  slot_reel_engine #(
    .REELS(REELS), .SYMBOLS(SYMBOLS), .SPIN_DIV(SPIN_DIV), .SCAN_DIV(SCAN_DIV),
    .FEVER_CYCLES(FEVER_CYCLES), .LED_W(LED_W), .CREDIT_W(CREDIT_W),
    .INIT_CREDIT(INIT_CREDIT), .PAYOUT(PAYOUT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .reel(reel),
    .digit(digit), .scan_symbol(scan_symbol), .running(running), .fever(fever),
    .led(led), .credit(credit)
  );

  always #5 clock = ~clock;

  int n_cmp = 0, n_err = 0;

  // Model: reel positions derived from elapsed time since the accepted start.
  int m_mode, cyc, t_spin, t_fev, m_credit;
  int base [REELS];
  int fval [REELS];
  bit frz  [REELS];
  bit p_start;
  bit [REELS-1:0] p_stop;

  function automatic int reel_at(int i, int c);
    if (frz[i]) return fval[i];
    return (base[i] + (c - t_spin - 1) / SPIN_DIV) % SYMBOLS;
  endfunction

  function automatic bit credit_ok();
`ifdef SLOT_CREDIT_EN
    return m_credit != 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; cyc = 0; t_spin = 0; t_fev = 0; p_start = 0; p_stop = '0;
    for (int i = 0; i < REELS; i++) begin frz[i] = 1; fval[i] = 0; base[i] = 0; end
`ifdef SLOT_CREDIT_EN
    m_credit = INIT_CREDIT;
`else
    m_credit = 0;
`endif
  endtask

  task automatic model_edge();
    bit se, all, eq;
    bit [REELS-1:0] ste;
    se  = start && !p_start;
    ste = stop & ~p_stop;
    case (m_mode)
      M_IDLE: if (se && credit_ok()) begin
        m_mode = M_SPIN; t_spin = cyc;
        for (int i = 0; i < REELS; i++) begin base[i] = fval[i]; frz[i] = 0; end
`ifdef SLOT_CREDIT_EN
        m_credit--;
`endif
      end
      M_SPIN: begin
        all = 1;
        for (int i = 0; i < REELS; i++) begin
          if (!frz[i] && ste[i]) begin fval[i] = reel_at(i, cyc); frz[i] = 1; end
          all &= frz[i];
        end
        if (all) m_mode = M_JUDGE;
      end
      M_JUDGE: begin
        eq = 1;
        for (int i = 1; i < REELS; i++) eq &= (fval[i] == fval[0]);
        if (eq) begin
          m_mode = M_FEVER; t_fev = cyc + 1;
`ifdef SLOT_CREDIT_EN
          m_credit = (m_credit + PAYOUT > 2**CREDIT_W - 1) ? 2**CREDIT_W - 1 : m_credit + PAYOUT;
`endif
        end else m_mode = M_IDLE;
      end
      default: if (cyc + 1 - t_fev == FEVER_CYCLES) m_mode = M_IDLE;
    endcase
    p_start = start; p_stop = stop; cyc++;
  endtask

  task automatic check_outputs();
    logic [REELS*SYM_W-1:0] er;
    logic [LED_W-1:0] el;
    int idx;
    for (int i = 0; i < REELS; i++) er[i*SYM_W +: SYM_W] = SYM_W'(reel_at(i, cyc));
    idx = (cyc / SCAN_DIV) % REELS;
    el  = (m_mode == M_FEVER) ? LED_W'(1) << (((cyc - t_fev) / SPIN_DIV) % LED_W) : '0;
    chk("reel", 64'(reel), 64'(er));
    chk("digit", 64'(digit), 64'(REELS'(1) << idx));
    chk("scan_symbol", 64'(scan_symbol), 64'(reel_at(idx, cyc)));
    chk("running", 64'(running), 64'(m_mode == M_SPIN));
    chk("fever", 64'(fever), 64'(m_mode == M_FEVER));
    chk("led", 64'(led), 64'(el));
    chk("credit", 64'(credit), 64'(m_credit));
  endtask

  task automatic step();
    if (reset) model_reset();
    else       model_edge();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  typedef struct packed {
    logic [REELS-1:0][3:0] tgt;
    logic                  win;
  } vec_t;

  // Spin, stop each reel when it shows its target, then let judge/fever play out.
  task automatic run_round(input vec_t v);
    logic [REELS-1:0] pressed;
    logic [REELS*SYM_W-1:0] er;
    int fc;
    pulse_start();
    pressed = '0;
    for (int k = 0; k < 200 && pressed != '1; k++) begin
      stop = '0;
      for (int i = 0; i < REELS; i++)
        if (!pressed[i] && reel_at(i, cyc) == int'(v.tgt[i])) begin
          stop[i] = 1'b1; pressed[i] = 1'b1;
        end
      step();
    end
    stop = '0;
    chk("round_stop_timeout", 64'(pressed), 64'({REELS{1'b1}}));
    fc = 0;
    for (int k = 0; k < FEVER_CYCLES + 16; k++) begin step(); if (fever) fc++; end
    for (int i = 0; i < REELS; i++) er[i*SYM_W +: SYM_W] = v.tgt[i][SYM_W-1:0];
    chk("round_reels", 64'(reel), 64'(er));
    chk("round_fever_len", 64'(fc), 64'(v.win ? FEVER_CYCLES : 0));
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = '0;
    step();
    chk("rst_reel", 64'(reel), 64'(0));
    chk("rst_digit", 64'(digit), 64'(1));
    chk("rst_led", 64'(led), 64'(0));
    chk("rst_running", 64'(running), 64'(0));
    chk("rst_fever", 64'(fever), 64'(0));
`ifdef SLOT_CREDIT_EN
    chk("rst_credit", 64'(credit), 64'(INIT_CREDIT));
`else
    chk("rst_credit", 64'(credit), 64'(0));
`endif
    reset = 1'b0;
  endtask

  vec_t vt [4];
  int   tc;
  logic [SYM_W-1:0] v0;

  initial begin
    vt[0] = '{tgt: {4'd3, 4'd3, 4'd3}, win: 1'b1};
    vt[1] = '{tgt: {4'd2, 4'd5, 4'd2}, win: 1'b0};
    vt[2] = '{tgt: {4'd7, 4'd7, 4'd7}, win: 1'b1};
    vt[3] = '{tgt: {4'd0, 4'd1, 4'd0}, win: 1'b0};

    do_reset();
    repeat (16) step();
    chk("scan_16", 64'(digit), 64'(3'b010));
    repeat (16) step();
    chk("scan_32", 64'(digit), 64'(3'b100));
    repeat (16) step();
    chk("scan_48", 64'(digit), 64'(3'b001));

    // Free spin for 40 cycles with a second start press ignored, then a win.
    do_reset();
    pulse_start();
    for (int k = 0; k < 40; k++) begin start = (k == 10); step(); end
    start = 1'b0;
    chk("spin_running", 64'(running), 64'(1));
    stop = '1; step(); stop = '0;
    repeat (FEVER_CYCLES + 4) step();

    do_reset();
    for (int r = 0; r < 4; r++) begin
      run_round(vt[r]);
`ifdef SLOT_CREDIT_EN
      if (r == 0) chk("credit_win", 64'(credit), 64'(14));
`endif
    end

    // Stop on a tick cycle keeps the pre-tick value; repeat stop is ignored.
    pulse_start();
    tc = 0;
    while (!((cyc - t_spin) % SPIN_DIV == 0 && cyc > t_spin + SPIN_DIV) && tc < 20) begin
      step(); tc++;
    end
    v0 = SYM_W'(reel_at(0, cyc));
    stop = 3'b001; step(); stop = '0;
    chk("tick_stop_hold", 64'(reel[SYM_W-1:0]), 64'(v0));
    repeat (6) step();
    stop = 3'b001; step(); stop = '0;
    chk("repeat_stop_running", 64'(running), 64'(1));
    chk("repeat_stop_hold", 64'(reel[SYM_W-1:0]), 64'(v0));
    stop = 3'b110; step(); stop = '0;
    repeat (FEVER_CYCLES + 4) step();

    // Stop held from before start does not freeze until pressed again.
    stop = 3'b001; step();
    pulse_start();
    repeat (12) step();
    chk("held_stop_running", 64'(running), 64'(1));
    stop = '0; step();
    stop = '1; step(); stop = '0;
    repeat (FEVER_CYCLES + 4) step();

    // Reset in the middle of a spin.
    pulse_start();
    repeat (10) step();
    do_reset();

`ifdef SLOT_CREDIT_EN
    for (int r = 0; r < INIT_CREDIT; r++) run_round('{tgt: {4'd2, 4'd1, 4'd0}, win: 1'b0});
    chk("credit_empty", 64'(credit), 64'(0));
    pulse_start();
    step();
    chk("credit_zero_start", 64'(running), 64'(0));
    do_reset();
    for (int r = 0; r < 28; r++) run_round('{tgt: {4'd3, 4'd3, 4'd3}, win: 1'b1});
    chk("credit_saturate", 64'(credit), 64'(255));
`endif

    do_reset();
    for (int k = 0; k < 3000; k++) begin
      start = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < REELS; i++) stop[i] = ($urandom_range(0, 11) == 0);
      step();
    end
    start = 1'b0; stop = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
